// File: rtl/ddr_axi_traffic_master.sv
// Per-port AXI traffic initiator: issues single AW/AR bursts, generates write pattern, checks read pattern.
// Optional read-data compare is built only when DDR_TM_RDCHECK_EN is defined.
module ddr_axi_traffic_master #(
  parameter int         CTRL_ADDR_WIDTH = 28,
  parameter int         MEM_DQ_WIDTH    = 32,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic                         core_clk,
  input  logic                         resetn,
  input  logic                         ddr_init_done,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [CTRL_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [3:0]                   cmd_len,
  input  logic                         cmd_ap,
  input  logic [31:0]                  cmd_seed,
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [3:0]                   axi_awlen,
  output logic [3:0]                   axi_awuser_id,
  output logic                         axi_awuser_ap,
  output logic                         axi_awvalid,
  input  logic                         axi_awready,
  output logic [MEM_DQ_WIDTH*8-1:0]    axi_wdata,
  output logic [MEM_DQ_WIDTH-1:0]      axi_wstrb,
  input  logic                         axi_wready,
  input  logic [3:0]                   axi_wusero_id,
  input  logic                         axi_wusero_last,
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [3:0]                   axi_arlen,
  output logic [3:0]                   axi_aruser_id,
  output logic                         axi_aruser_ap,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
  input  logic [3:0]                   axi_rid,
  input  logic                         axi_rlast,
  input  logic                         axi_rvalid,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  err_cnt,
  output logic                         err_flag,
  output logic                         proto_err
);
  // state   | meaning
  // S_IDLE  | waiting for a command (ready once DDR init is done)
  // S_AW    | write address presented, waiting for awready
  // S_WDATA | streaming write beats on wready
  // S_AR    | read address presented, waiting for arready
  // S_RDATA | collecting read beats on rvalid
  localparam int LANES = MEM_DQ_WIDTH / 4;
  localparam int DW    = MEM_DQ_WIDTH * 8;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_WDATA, S_AR, S_RDATA} state_t;

  state_t                       state, state_nxt;
  logic [CTRL_ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]                   len_q;
  logic                         ap_q;
  logic [31:0]                  seed_q;
  logic [3:0]                   beat_q;
  logic                         done_q;
  logic                         proto_q;
  logic                         cmd_accept;
  logic                         w_beat;
  logic                         r_beat;
  logic                         last_beat;
  logic                         proto_hit;
  logic [DW-1:0]                beat_pattern;

  function automatic logic [DW-1:0] pattern(input logic [31:0] seed, input logic [3:0] beat);
    logic [DW-1:0] p;
    p = '0;
    for (int k = 0; k < LANES; k++)
      p[k*32 +: 32] = seed + 32'(beat) * 32'(LANES) + 32'(k);
    return p;
  endfunction

  assign cmd_ready    = (state == S_IDLE) & ddr_init_done;
  assign cmd_accept   = cmd_valid & cmd_ready;
  assign w_beat       = (state == S_WDATA) & axi_wready;
  assign r_beat       = (state == S_RDATA) & axi_rvalid;
  assign last_beat    = (beat_q == len_q);
  assign beat_pattern = pattern(seed_q, beat_q);

  always_comb begin
    state_nxt   = state;
    axi_awvalid = 1'b0;
    axi_arvalid = 1'b0;
    case (state)
      S_IDLE:  if (cmd_accept) state_nxt = cmd_write ? S_AW : S_AR;
      S_AW: begin
        axi_awvalid = 1'b1;
        if (axi_awready) state_nxt = S_WDATA;
      end
      S_WDATA: if (w_beat && last_beat) state_nxt = S_IDLE;
      S_AR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_nxt = S_RDATA;
      end
      S_RDATA: if (r_beat && last_beat) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Protocol checks only flag; burst length is governed by the local beat count.
  assign proto_hit = (axi_wready & (state != S_WDATA))
                   | (axi_rvalid & (state != S_RDATA))
                   | (w_beat & ((axi_wusero_last != last_beat) | (axi_wusero_id != AXI_ID)))
                   | (axi_rvalid & ((axi_rid != AXI_ID) | (r_beat & (axi_rlast != last_beat))));

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      ap_q    <= 1'b0;
      seed_q  <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (w_beat | r_beat) & last_beat;
      if (proto_hit) proto_q <= 1'b1;
      if (cmd_accept) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        ap_q   <= cmd_ap;
        seed_q <= cmd_seed;
        beat_q <= '0;
      end else if (w_beat | r_beat) begin
        beat_q <= beat_q + 4'd1;
      end
    end
  end

  assign axi_awaddr    = addr_q;
  assign axi_awlen     = len_q;
  assign axi_awuser_id = AXI_ID;
  assign axi_awuser_ap = ap_q;
  assign axi_araddr    = addr_q;
  assign axi_arlen     = len_q;
  assign axi_aruser_id = AXI_ID;
  assign axi_aruser_ap = ap_q;
  assign axi_wstrb     = '1;
  assign axi_wdata     = (state == S_WDATA) ? beat_pattern : '0;
  assign busy          = (state != S_IDLE);
  assign done          = done_q;
  assign proto_err     = proto_q;

`ifdef DDR_TM_RDCHECK_EN
  logic [15:0] err_cnt_q;
  logic        err_flag_q;

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else if (cmd_accept && !cmd_write) begin
      err_cnt_q <= '0;
    end else if (r_beat && (axi_rdata != beat_pattern)) begin
      err_flag_q <= 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;
`else
  logic rdata_unused;
  assign rdata_unused = ^axi_rdata;
  assign err_cnt      = '0;
  assign err_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_axi_traffic_master.sv
// Directed self-checking bench for ddr_axi_traffic_master (default parameters).
// Read-compare expectations follow DDR_TM_RDCHECK_EN the same way the design does.
module tb_ddr_axi_traffic_master;
`ifdef DDR_TM_RDCHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         core_clk = 1'b0;
  logic         resetn;
  logic         ddr_init_done;
  logic         cmd_valid, cmd_ready, cmd_write, cmd_ap;
  logic [27:0]  cmd_addr;
  logic [3:0]   cmd_len;
  logic [31:0]  cmd_seed;
  logic [27:0]  axi_awaddr, axi_araddr;
  logic [3:0]   axi_awlen, axi_awuser_id, axi_arlen, axi_aruser_id;
  logic         axi_awuser_ap, axi_awvalid, axi_awready;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wready, axi_wusero_last;
  logic [3:0]   axi_wusero_id;
  logic         axi_aruser_ap, axi_arvalid, axi_arready;
  logic [255:0] axi_rdata;
  logic [3:0]   axi_rid;
  logic         axi_rlast, axi_rvalid;
  logic         busy, done, err_flag, proto_err;
  logic [15:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [255:0] wq[$];
  logic [255:0] rq[$];
  logic [255:0] cap [16];

  always #5 core_clk = ~core_clk;

  ddr_axi_traffic_master dut (
    .core_clk(core_clk), .resetn(resetn), .ddr_init_done(ddr_init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ap(cmd_ap), .cmd_seed(cmd_seed),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awuser_id(axi_awuser_id),
    .axi_awuser_ap(axi_awuser_ap), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_wusero_id(axi_wusero_id), .axi_wusero_last(axi_wusero_last),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_aruser_id(axi_aruser_id),
    .axi_aruser_ap(axi_aruser_ap), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .busy(busy), .done(done), .err_cnt(err_cnt), .err_flag(err_flag), .proto_err(proto_err)
  );

  function automatic logic [255:0] tb_pattern(input logic [31:0] seed, input int beat);
    logic [255:0] p;
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = seed + 32'(beat * 8 + k);
    return p;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [27:0] addr, input logic [3:0] len, input logic [31:0] seed,
                          input int aw_delay, input int bad_last_beat);
    int aw_cycles;
    logic [255:0] exp;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
    cmd_seed = seed; cmd_ap = 1'b1;
    for (int b = 0; b <= int'(len); b++) wq.push_back(tb_pattern(seed, b));
    @(negedge core_clk);
    cmd_valid = 1'b0;
    check("awaddr", axi_awaddr, addr);
    check("awlen", axi_awlen, len);
    aw_cycles = 0;
    for (int c = 0; c <= aw_delay; c++) begin
      if (axi_awvalid) aw_cycles++;
      axi_awready = (c == aw_delay);
      @(negedge core_clk);
    end
    axi_awready = 1'b0;
    check("awvalid_cycles", aw_cycles, aw_delay + 1);
    check("awvalid_drop", axi_awvalid, 1'b0);
    for (int b = 0; b <= int'(len); b++) begin
      exp = (wq.size() > 0) ? wq.pop_front() : '0;
      check("wdata", axi_wdata, exp);
      cap[b] = axi_wdata;
      axi_wready = 1'b1;
      axi_wusero_last = (b == bad_last_beat) ? 1'b1 : (b == int'(len));
      @(negedge core_clk);
    end
    axi_wready = 1'b0; axi_wusero_last = 1'b0;
    check("wr_done", done, 1'b1);
    check("wr_busy", busy, 1'b0);
    check("wr_cmd_ready", cmd_ready, 1'b1);
    @(negedge core_clk);
    check("wr_done_pulse", done, 1'b0);
  endtask

  task automatic do_read(input logic [27:0] addr, input logic [3:0] len, input logic [31:0] seed,
                         input int bad_beat, input logic [3:0] rid_val, input bit gap);
    logic [255:0] d;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    cmd_seed = seed; cmd_ap = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      d = tb_pattern(seed, b);
      if (b == bad_beat) d[5*32 +: 32] = d[5*32 +: 32] ^ 32'h1;
      rq.push_back(d);
    end
    @(negedge core_clk);
    cmd_valid = 1'b0;
    check("arvalid", axi_arvalid, 1'b1);
    check("araddr", axi_araddr, addr);
    check("rd_err_cnt_clear", err_cnt, 16'd0);
    axi_arready = 1'b1;
    @(negedge core_clk);
    axi_arready = 1'b0;
    check("arvalid_drop", axi_arvalid, 1'b0);
    for (int b = 0; b <= int'(len); b++) begin
      if (gap && b > 0) begin
        axi_rvalid = 1'b0;
        @(negedge core_clk);
      end
      axi_rvalid = 1'b1;
      axi_rdata  = (rq.size() > 0) ? rq.pop_front() : '0;
      axi_rid    = rid_val;
      axi_rlast  = (b == int'(len));
      @(negedge core_clk);
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0; axi_rid = 4'd0;
    check("rd_done", done, 1'b1);
    check("rd_busy", busy, 1'b0);
    @(negedge core_clk);
    check("rd_done_pulse", done, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; ddr_init_done = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_ap = 1'b0; cmd_seed = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_wusero_id = 4'd0; axi_wusero_last = 1'b0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rid = 4'd0; axi_rlast = 1'b0; axi_rvalid = 1'b0;

    repeat (3) @(negedge core_clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_awvalid", axi_awvalid, 1'b0);
    check("rst_arvalid", axi_arvalid, 1'b0);
    check("rst_err_cnt", err_cnt, 16'd0);
    check("rst_err_flag", err_flag, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_awaddr", axi_awaddr, 28'd0);
    check("rst_wdata", axi_wdata, 256'd0);
    check("wstrb", axi_wstrb, 32'hFFFF_FFFF);
    resetn = 1'b1;
    @(negedge core_clk);
    check("ready_before_init", cmd_ready, 1'b0);
    ddr_init_done = 1'b1;
    @(negedge core_clk);
    check("ready_after_init", cmd_ready, 1'b1);

    do_write(28'h0001234, 4'd3, 32'h100, 2, -1);
    check("beat0_lane0", cap[0][31:0], 32'h100);
    check("beat3_lane7", cap[3][255:224], 32'h11F);
    check("wr_proto_err", proto_err, 1'b0);

    do_read(28'h0000040, 4'd3, 32'h100, -1, 4'd0, 1'b1);
    check("clean_err_cnt", err_cnt, 16'd0);
    check("clean_err_flag", err_flag, 1'b0);
    check("clean_proto_err", proto_err, 1'b0);

    do_read(28'h0000040, 4'd3, 32'h100, 2, 4'd0, 1'b1);
    check("bad_err_cnt", err_cnt, CHK ? 16'd1 : 16'd0);
    check("bad_err_flag", err_flag, CHK);

    do_read(28'h0000080, 4'd3, 32'h2000, -1, 4'd0, 1'b0);
    check("reclean_err_cnt", err_cnt, 16'd0);
    check("sticky_err_flag", err_flag, CHK);
    check("reclean_proto_err", proto_err, 1'b0);

    do_write(28'h0000200, 4'd1, 32'hABCD_0000, 0, 0);
    check("wlast_proto_err", proto_err, 1'b1);

    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 28'h0000300; cmd_len = 4'd3; cmd_seed = 32'h55;
    @(negedge core_clk);
    cmd_valid = 1'b0; axi_awready = 1'b1;
    @(negedge core_clk);
    axi_awready = 1'b0; axi_wready = 1'b1; axi_wusero_last = 1'b0;
    @(negedge core_clk);
    @(negedge core_clk);
    check("abort_busy", busy, 1'b1);
    resetn = 1'b0; ddr_init_done = 1'b0; axi_wready = 1'b0;
    #1;
    check("abort_busy_drop", busy, 1'b0);
    check("abort_awvalid", axi_awvalid, 1'b0);
    check("abort_wdata", axi_wdata, 256'd0);
    check("abort_proto_err", proto_err, 1'b0);
    check("abort_err_flag", err_flag, 1'b0);
    check("abort_cmd_ready", cmd_ready, 1'b0);
    @(negedge core_clk);
    resetn = 1'b1;
    repeat (3) @(negedge core_clk);
    check("post_rst_ready_no_init", cmd_ready, 1'b0);
    ddr_init_done = 1'b1;
    @(negedge core_clk);
    check("post_rst_ready", cmd_ready, 1'b1);

    do_read(28'h0000400, 4'd3, 32'h55, -1, 4'h5, 1'b1);
    check("rid_proto_err", proto_err, 1'b1);
    check("rid_err_cnt", err_cnt, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
